// File: rtl/reg_wb_arbiter.sv
// Writeback arbiter: shares the reg_file write port between MEM load returns and ALU results.
// Optional WB_ARB_STATS_EN adds saturating STALL_CNT / KILL_CNT counters.
module reg_wb_arbiter #(
   parameter int DEPTH = 4,
   parameter int DW    = 8,
   parameter int AW    = 3
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic                ALU_VALID,
   input  logic [AW-1:0]       ALU_ADDR,
   input  logic [DW-1:0]       ALU_DATA,
   input  logic                MEM_VALID,
   input  logic [AW-1:0]       MEM_ADDR,
   input  logic [DW-1:0]       MEM_DATA,
   output logic                WR_EN,
   output logic [AW-1:0]       WR_ADDR,
   output logic [DW-1:0]       WR_DATA,
   output logic [2**AW-1:0]    PENDING,
   output logic                STALL,
`ifdef WB_ARB_STATS_EN
   output logic [7:0]          STALL_CNT,
   output logic [7:0]          KILL_CNT,
`endif
   output logic                OVERFLOW
);

   localparam int PW = $clog2(DEPTH);
   localparam int NR = 2**AW;

   function automatic logic [NR-1:0] onehot(input logic [AW-1:0] a);
      onehot = NR'(1) << a;
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      sat_inc = (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   logic [AW-1:0]    addr_q [DEPTH];
   logic [DW-1:0]    data_q [DEPTH];
   logic [DEPTH-1:0] live_q, live_d;
   logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
   logic [PW:0]      cnt_q, cnt_d;
   logic             wr_en_q, wr_en_d;
   logic [AW-1:0]    wr_addr_q, wr_addr_d;
   logic [DW-1:0]    wr_data_q, wr_data_d;
   logic [NR-1:0]    pend_q, pend_d;
   logic             stall_q, ovf_q, ovf_d;

   logic [DEPTH-1:0] hit;
   logic             same_addr, alu_direct, fifo_grant, pop, push, want_push, full, any_kill;

   always_comb begin
      hit        = '0;
      for (int i = 0; i < DEPTH; i++)
         hit[i] = MEM_VALID && live_q[i] && (addr_q[i] == MEM_ADDR);
      any_kill   = |hit;
      same_addr  = ALU_VALID && MEM_VALID && (ALU_ADDR == MEM_ADDR);
      full       = (cnt_q == (PW+1)'(DEPTH));
      fifo_grant = !MEM_VALID && live_q[head_q];
      alu_direct = ALU_VALID && !MEM_VALID && (live_q == '0);
      // A head killed by this cycle's MEM write is retired now, alongside the MEM grant.
      pop        = (cnt_q != '0) && (fifo_grant || !(live_q[head_q] && !hit[head_q]));
      want_push  = ALU_VALID && !alu_direct && !same_addr;
      push       = want_push && (!full || pop);
      ovf_d      = ovf_q || (want_push && full && !pop);

      live_d = live_q & ~hit;
      if (pop)
         live_d[head_q] = 1'b0;
      if (push)
         live_d[tail_q] = 1'b1;
      head_d = pop  ? head_q + PW'(1) : head_q;
      tail_d = push ? tail_q + PW'(1) : tail_q;
      cnt_d  = cnt_q + (PW+1)'(push) - (PW+1)'(pop);

      wr_en_d   = 1'b1;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      if (MEM_VALID) begin
         wr_addr_d = MEM_ADDR;
         wr_data_d = MEM_DATA;
      end else if (fifo_grant) begin
         wr_addr_d = addr_q[head_q];
         wr_data_d = data_q[head_q];
      end else if (alu_direct) begin
         wr_addr_d = ALU_ADDR;
         wr_data_d = ALU_DATA;
      end else begin
         wr_en_d = 1'b0;
      end

      pend_d = wr_en_d ? onehot(wr_addr_d) : '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (live_d[i])
            pend_d = pend_d | onehot((push && PW'(i) == tail_q) ? ALU_ADDR : addr_q[i]);
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         live_q    <= '0;
         head_q    <= '0;
         tail_q    <= '0;
         cnt_q     <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         pend_q    <= '0;
         stall_q   <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         live_q    <= live_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         cnt_q     <= cnt_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         pend_q    <= pend_d;
         stall_q   <= (cnt_d == (PW+1)'(DEPTH));
         ovf_q     <= ovf_d;
      end
   end

   // FIFO payload storage; validity is tracked solely by live_q.
   always_ff @(posedge CLK) begin
      if (push) begin
         addr_q[tail_q] <= ALU_ADDR;
         data_q[tail_q] <= ALU_DATA;
      end
   end

`ifdef WB_ARB_STATS_EN
   logic [7:0] stall_cnt_q, kill_cnt_q;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         stall_cnt_q <= '0;
         kill_cnt_q  <= '0;
      end else begin
         if (stall_q)
            stall_cnt_q <= sat_inc(stall_cnt_q);
         if (any_kill || same_addr)
            kill_cnt_q <= sat_inc(kill_cnt_q);
      end
   end

   assign STALL_CNT = stall_cnt_q;
   assign KILL_CNT  = kill_cnt_q;
`else
   logic unused_stats;
   assign unused_stats = ^{any_kill, sat_inc(8'h00)};
`endif

   assign WR_EN    = wr_en_q;
   assign WR_ADDR  = wr_addr_q;
   assign WR_DATA  = wr_data_q;
   assign PENDING  = pend_q;
   assign STALL    = stall_q;
   assign OVERFLOW = ovf_q;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Scoreboard bench for reg_wb_arbiter: expected writes queued by stimulus, popped by a negedge monitor.
module tb_reg_wb_arbiter;

   logic       CLK = 1'b0;
   logic       RESET;
   logic       ALU_VALID, MEM_VALID;
   logic [2:0] ALU_ADDR, MEM_ADDR, WR_ADDR;
   logic [7:0] ALU_DATA, MEM_DATA, WR_DATA, PENDING;
   logic       WR_EN, STALL, OVERFLOW;
`ifdef WB_ARB_STATS_EN
   logic [7:0] STALL_CNT, KILL_CNT;
`endif

   int checks = 0;
   int errors = 0;
   logic [10:0] sb [$];
   logic [7:0]  rf [8];

   reg_wb_arbiter #(.DEPTH(4), .DW(8), .AW(3)) dut (
      .CLK(CLK), .RESET(RESET),
      .ALU_VALID(ALU_VALID), .ALU_ADDR(ALU_ADDR), .ALU_DATA(ALU_DATA),
      .MEM_VALID(MEM_VALID), .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA),
      .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
      .PENDING(PENDING), .STALL(STALL),
`ifdef WB_ARB_STATS_EN
      .STALL_CNT(STALL_CNT), .KILL_CNT(KILL_CNT),
`endif
      .OVERFLOW(OVERFLOW)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic expect_wr(input logic [2:0] a, input logic [7:0] d);
      sb.push_back({a, d});
   endtask

   // One cycle of stimulus; returns #1 after the posedge that consumes it.
   task automatic cyc(input logic av, input logic [2:0] aa, input logic [7:0] ad,
                      input logic mv, input logic [2:0] ma, input logic [7:0] md);
      ALU_VALID = av; ALU_ADDR = aa; ALU_DATA = ad;
      MEM_VALID = mv; MEM_ADDR = ma; MEM_DATA = md;
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      cyc(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
   endtask

   initial begin
      RESET = 1'b1;
      ALU_VALID = 1'b0; ALU_ADDR = '0; ALU_DATA = '0;
      MEM_VALID = 1'b0; MEM_ADDR = '0; MEM_DATA = '0;
      for (int i = 0; i < 8; i++) rf[i] = 8'h00;

      fork
         forever begin
            @(negedge CLK);
            if (!RESET && WR_EN) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_write actual=%0h:%0h required=none", WR_ADDR, WR_DATA);
               end else begin
                  logic [10:0] e;
                  e = sb.pop_front();
                  chk("wr_addr_data", {5'd0, WR_ADDR, WR_DATA}, {5'd0, e});
               end
            end
         end
         forever begin
            @(posedge CLK);
            if (!RESET && WR_EN) rf[WR_ADDR] = WR_DATA;
         end
      join_none

      // Reset then idle
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_wr_en", {15'd0, WR_EN}, 16'd0);
      chk("rst_wr_addr", {13'd0, WR_ADDR}, 16'd0);
      chk("rst_wr_data", {8'd0, WR_DATA}, 16'd0);
      chk("rst_pending", {8'd0, PENDING}, 16'h00);
      chk("rst_stall", {15'd0, STALL}, 16'd0);
      chk("rst_overflow", {15'd0, OVERFLOW}, 16'd0);
      RESET = 1'b0;
      idle();

      // ALU only
      expect_wr(3'd2, 8'h15);
      cyc(1'b1, 3'd2, 8'h15, 1'b0, 3'd0, 8'h00);
      chk("alu_wr_en", {15'd0, WR_EN}, 16'd1);
      chk("alu_pending", {8'd0, PENDING}, 16'h04);
      idle();
      chk("alu_reg2", {8'd0, rf[2]}, 16'h15);
      chk("alu_idle_pending", {8'd0, PENDING}, 16'h00);

      // Collision: MEM first, queued ALU next
      expect_wr(3'd3, 8'h55);
      expect_wr(3'd1, 8'hAA);
      cyc(1'b1, 3'd1, 8'hAA, 1'b1, 3'd3, 8'h55);
      chk("coll_pending1", {8'd0, PENDING}, 16'h0A);
      idle();
      chk("coll_pending2", {8'd0, PENDING}, 16'h02);
      idle();
      chk("coll_pending3", {8'd0, PENDING}, 16'h00);

      // Kill: queued r4 entry superseded by MEM r4
      expect_wr(3'd5, 8'h66);
      expect_wr(3'd4, 8'h22);
      cyc(1'b1, 3'd4, 8'h11, 1'b1, 3'd5, 8'h66);
      chk("kill_pending1", {8'd0, PENDING}, 16'h30);
      cyc(1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 8'h22);
      chk("kill_pending2", {8'd0, PENDING}, 16'h10);
      idle();
      idle();
      chk("kill_reg4", {8'd0, rf[4]}, 16'h22);
`ifdef WB_ARB_STATS_EN
      chk("kill_cnt1", {8'd0, KILL_CNT}, 16'd1);
`endif

      // Same-address ALU and MEM: ALU discarded, not an overflow
      expect_wr(3'd6, 8'h77);
      cyc(1'b1, 3'd6, 8'h01, 1'b1, 3'd6, 8'h77);
      chk("same_pending", {8'd0, PENDING}, 16'h40);
      idle();
      idle();
      chk("same_reg6", {8'd0, rf[6]}, 16'h77);
      chk("same_overflow", {15'd0, OVERFLOW}, 16'd0);
`ifdef WB_ARB_STATS_EN
      chk("kill_cnt2", {8'd0, KILL_CNT}, 16'd2);
`endif

      // Full: MEM r7 held while five ALU writes arrive
      for (int i = 0; i < 5; i++) expect_wr(3'd7, 8'h70 + 8'(i));
      for (int i = 0; i < 4; i++) expect_wr(3'(i), 8'hA0 + 8'(i));
      for (int i = 0; i < 4; i++) cyc(1'b1, 3'(i), 8'hA0 + 8'(i), 1'b1, 3'd7, 8'h70 + 8'(i));
      chk("full_stall", {15'd0, STALL}, 16'd1);
      chk("full_ovf_before", {15'd0, OVERFLOW}, 16'd0);
      cyc(1'b1, 3'd4, 8'hA4, 1'b1, 3'd7, 8'h74);
      chk("full_overflow", {15'd0, OVERFLOW}, 16'd1);
      chk("full_pending", {8'd0, PENDING}, 16'h8F);
      idle();
      chk("drain_stall", {15'd0, STALL}, 16'd0);
      repeat (4) idle();
      chk("drain_pending", {8'd0, PENDING}, 16'h00);
      chk("drain_reg3", {8'd0, rf[3]}, 16'hA3);
      chk("drain_reg4_kept", {8'd0, rf[4]}, 16'h22);
      chk("ovf_sticky", {15'd0, OVERFLOW}, 16'd1);
`ifdef WB_ARB_STATS_EN
      chk("stall_cnt", {8'd0, STALL_CNT}, 16'd2);
`endif

      // Async reset with three entries queued
      for (int i = 0; i < 3; i++) expect_wr(3'd7, 8'h80 + 8'(i));
      for (int i = 0; i < 3; i++) cyc(1'b1, 3'(i + 1), 8'hB0 + 8'(i), 1'b1, 3'd7, 8'h80 + 8'(i));
      chk("pre_rst_pending", {8'd0, PENDING}, 16'h8E);
      @(negedge CLK);
      #1;
      ALU_VALID = 1'b0;
      MEM_VALID = 1'b0;
      RESET = 1'b1;
      #1;
      chk("arst_wr_en", {15'd0, WR_EN}, 16'd0);
      chk("arst_pending", {8'd0, PENDING}, 16'h00);
      chk("arst_overflow", {15'd0, OVERFLOW}, 16'd0);
      repeat (2) @(posedge CLK);
      #1;
      RESET = 1'b0;
      repeat (8) idle();
      chk("post_rst_pending", {8'd0, PENDING}, 16'h00);
      chk("post_rst_reg1", {8'd0, rf[1]}, 16'hA1);
      chk("sb_empty", 16'(sb.size()), 16'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
